roulette_timer: RTL and testbench
=================================

ROULETTE_TIMER -- requirements
Module: roulette_timer

Interface
REQ-001 The module SHALL have parameter CNT_W, default 32, width of prescaler, autoreload and count.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 tim_prescaler  input  CNT_W  tick divider; one count tick every (tim_prescaler+1) enabled clk cycles.
REQ-005 tim_autoreload  input  CNT_W  terminal count value.
REQ-006 tim_clear  input  1  synchronous clear of counters, returns to IDLE.
REQ-007 tim_enable  input  1  run/start request; low pauses counting.
REQ-008 tim_mode  input  1  0 = one-shot, 1 = periodic (auto-reload).
REQ-009 tim_count  output  CNT_W  current count, registered.
REQ-010 timer_int  output  1  update-event pulse, registered, one clk wide.

Function
REQ-011 The block SHALL implement states IDLE, RUN, DONE plus internal presc_cnt, psc_sh and arr_sh registers (CNT_W each).
REQ-012 IDLE: tim_enable=1 SHALL latch psc_sh<=tim_prescaler, arr_sh<=tim_autoreload, presc_cnt<=0, tim_count<=0, next state RUN.
REQ-013 RUN, tim_enable=1: presc_cnt SHALL increment each cycle; when presc_cnt==psc_sh it SHALL return to 0 and generate a tick that cycle.
REQ-014 On tick with tim_count!=arr_sh, tim_count SHALL increment by 1.
REQ-015 On tick with tim_count==arr_sh (update event), timer_int SHALL be 1 in the following cycle only.
REQ-016 Update event, tim_mode=1: tim_count<=0, re-latch psc_sh/arr_sh from inputs, stay RUN.
REQ-017 Update event, tim_mode=0: tim_count holds arr_sh, next state DONE.
REQ-018 tim_mode SHALL be sampled live; only the value at the update event matters.
REQ-019 RUN, tim_enable=0: presc_cnt and tim_count SHALL hold; state stays RUN; resumes without loss when enable returns.
REQ-020 DONE: tim_count SHALL hold, no further timer_int; tim_enable=0 SHALL move to IDLE with tim_count retained.
REQ-021 Period between consecutive periodic timer_int pulses SHALL be exactly (arr_sh+1)*(psc_sh+1) cycles with enable held high.
REQ-022 First timer_int SHALL assert (arr_sh+1)*(psc_sh+1) cycles after the cycle in which the IDLE->RUN transition occurs, plus 1 register cycle.
REQ-023 psc_sh=0 SHALL tick every cycle; arr_sh=0 SHALL update on every tick; both 0 in periodic mode SHALL give timer_int high continuously.
REQ-024 tim_clear SHALL take priority over all events: tim_count<=0, presc_cnt<=0, timer_int<=0, state<=IDLE, even on a coincident update event.
REQ-025 Changes to tim_prescaler/tim_autoreload during RUN SHALL have no effect until the next periodic reload or next IDLE->RUN.
REQ-026 Counters SHALL be unsigned CNT_W; no wrap beyond arr_sh is possible since tim_count never exceeds arr_sh.

Reset
REQ-027 rst=1 SHALL set state IDLE, tim_count=0, timer_int=0, presc_cnt=0, psc_sh=0, arr_sh=0 at the next edge, overriding tim_clear and tim_enable.
REQ-028 Reset asserted mid-RUN SHALL abort counting with no timer_int pulse emitted.

Verification
REQ-029 rst=1 two cycles with enable=1 -> tim_count=0, timer_int=0 throughout; counting starts only after rst=0.
REQ-030 Periodic psc=3, arr=4, enable held -> tim_count 0,1,2,3,4 each held 4 cycles; timer_int one-cycle pulses exactly 20 cycles apart over 5 periods.
REQ-031 One-shot psc=0, arr=9 -> single timer_int pulse, tim_count stays 9 for 50 further cycles; enable=0 -> IDLE, tim_count still 9; enable=1 -> restarts from 0.
REQ-032 Periodic psc=1, arr=5; enable low 10 cycles at tim_count=2 -> count frozen at 2, pulse delayed exactly 10 cycles versus uninterrupted run.
REQ-033 tim_clear asserted in the update-event cycle -> no timer_int, tim_count=0, state IDLE next cycle.
REQ-034 Periodic arr=4 changed to 7 mid-period -> current period still 5 ticks, subsequent periods 8 ticks.

Source files
------------

// File: rtl/roulette_timer.sv
// roulette_timer: prescaled up-counter with one-shot or periodic auto-reload.
//   clk            - single clock, all logic on the rising edge
//   rst            - synchronous active-high reset
//   tim_prescaler  - tick divider, one count tick every (tim_prescaler+1) enabled cycles
//   tim_autoreload - terminal count value
//   tim_clear      - synchronous clear of counters, returns to IDLE
//   tim_enable     - run/start request, low pauses counting
//   tim_mode       - 0 = one-shot, 1 = periodic
//   tim_count      - current count (registered)
//   timer_int      - one-cycle update-event pulse (registered)
module roulette_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] tim_prescaler,
  input  logic [CNT_W-1:0] tim_autoreload,
  input  logic             tim_clear,
  input  logic             tim_enable,
  input  logic             tim_mode,
  output logic [CNT_W-1:0] tim_count,
  output logic             timer_int
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] presc_cnt, presc_n;
  logic [CNT_W-1:0] psc_sh, psc_n;
  logic [CNT_W-1:0] arr_sh, arr_n;
  logic [CNT_W-1:0] count_n;
  logic             int_n;
  logic             tick;

  // Prescaler reaching its shadowed terminal value produces a count tick this cycle.
  assign tick = (presc_cnt == psc_sh);

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      presc_cnt <= '0;
      psc_sh    <= '0;
      arr_sh    <= '0;
      tim_count <= '0;
      timer_int <= 1'b0;
    end else begin
      state     <= state_n;
      presc_cnt <= presc_n;
      psc_sh    <= psc_n;
      arr_sh    <= arr_n;
      tim_count <= count_n;
      timer_int <= int_n;
    end
  end

  // Next-state and datapath update; clear wins over any coincident event.
  always_comb begin
    state_n = state;
    presc_n = presc_cnt;
    psc_n   = psc_sh;
    arr_n   = arr_sh;
    count_n = tim_count;
    int_n   = 1'b0;

    if (tim_clear) begin
      state_n = IDLE;
      presc_n = '0;
      count_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (tim_enable) begin
            psc_n   = tim_prescaler;
            arr_n   = tim_autoreload;
            presc_n = '0;
            count_n = '0;
            state_n = RUN;
          end
        end
        RUN: begin
          // Enable low simply freezes prescaler and count in place.
          if (tim_enable) begin
            if (tick) begin
              presc_n = '0;
              if (tim_count == arr_sh) begin
                int_n = 1'b1;
                if (tim_mode) begin
                  // Periodic reload picks up any new prescaler/autoreload values.
                  count_n = '0;
                  psc_n   = tim_prescaler;
                  arr_n   = tim_autoreload;
                end else begin
                  state_n = DONE;
                end
              end else begin
                count_n = tim_count + CNT_W'(1);
              end
            end else begin
              presc_n = presc_cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (!tim_enable) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_roulette_timer.sv
// Bench for roulette_timer: a vector table plus multi-cycle scenarios, with
// expected outputs queued as stimulus is driven and checked after each edge.
module tb_roulette_timer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, tim_clear, tim_enable, tim_mode;
  logic [W-1:0] tim_prescaler, tim_autoreload, tim_count;
  logic         timer_int;

  typedef struct {
    logic         rst, clr, en, mode;
    logic [W-1:0] psc, arr, cnt;
    logic         irq;
  } vec_t;

  typedef struct {
    logic [W-1:0] cnt;
    logic         irq;
    string        nm;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_pulse;

  roulette_timer #(.CNT_W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .tim_prescaler  (tim_prescaler),
    .tim_autoreload (tim_autoreload),
    .tim_clear      (tim_clear),
    .tim_enable     (tim_enable),
    .tim_mode       (tim_mode),
    .tim_count      (tim_count),
    .timer_int      (timer_int)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  task automatic add(input int r, c, e, m, p, a, cn, ir);
    vec_t v;
    v.rst = 1'(r); v.clr = 1'(c); v.en = 1'(e); v.mode = 1'(m);
    v.psc = W'(p); v.arr = W'(a); v.cnt = W'(cn); v.irq = 1'(ir);
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs, queue the expectation, check after the edge.
  task automatic step(input logic r, c, e, m, input logic [W-1:0] p, a,
                      input logic [W-1:0] ec, input logic ei, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; tim_clear = c; tim_enable = e; tim_mode = m;
    tim_prescaler = p; tim_autoreload = a;
    exp_q.push_back('{cnt: ec, irq: ei, nm: nm});
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    n_vec++;
    if (timer_int) n_pulse++;
    if (tim_count !== x.cnt || timer_int !== x.irq) begin
      n_bad++;
      $display("FAIL %s: got count=%0d int=%b, required count=%0d int=%b",
               x.nm, tim_count, timer_int, x.cnt, x.irq);
    end
  endtask

  initial begin
    rst = 1'b1; tim_clear = 1'b0; tim_enable = 1'b0; tim_mode = 1'b0;
    tim_prescaler = '0; tim_autoreload = '0;

    // rst clr en mode psc arr -> count int
    add(1,0,1,1, 1,2, 0,0);  // reset held with enable high
    add(1,0,1,1, 1,2, 0,0);
    add(0,0,1,1, 1,2, 0,0);  // IDLE->RUN
    add(0,0,1,1, 1,2, 0,0);
    add(0,0,1,1, 1,2, 1,0);
    add(0,0,1,1, 1,2, 1,0);
    add(0,0,1,1, 1,2, 2,0);
    add(0,0,1,1, 1,2, 2,0);
    add(0,0,1,1, 1,2, 0,1);  // periodic update event
    add(0,0,1,1, 1,2, 0,0);
    add(0,0,0,1, 1,2, 0,0);  // pause
    add(0,0,1,1, 1,2, 1,0);  // resume, tick pending
    add(0,1,1,1, 1,2, 0,0);  // clear
    add(0,0,0,1, 1,2, 0,0);
    add(0,0,1,1, 0,0, 0,0);  // psc=arr=0 periodic
    add(0,0,1,1, 0,0, 0,1);
    add(0,0,1,1, 0,0, 0,1);
    add(0,0,1,1, 0,0, 0,1);
    add(1,1,1,1, 0,0, 0,0);  // reset mid-run, overrides clear
    add(0,0,1,0, 0,1, 0,0);  // one-shot arr=1
    add(0,0,1,0, 0,1, 1,0);
    add(0,0,1,0, 0,1, 1,1);
    add(0,0,1,0, 0,1, 1,0);  // DONE holds
    add(0,0,1,0, 0,1, 1,0);
    add(0,0,0,0, 0,1, 1,0);  // DONE->IDLE keeps count
    add(0,0,0,0, 0,1, 1,0);
    add(0,0,1,0, 0,1, 0,0);  // restart
    add(0,0,1,0, 0,1, 1,0);
    add(0,1,1,0, 0,1, 0,0);  // clear on update-event cycle
    add(0,0,0,0, 0,1, 0,0);
    add(0,0,1,0, 0,1, 0,0);
    add(0,0,1,0, 0,1, 1,0);

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].clr, tbl[i].en, tbl[i].mode, tbl[i].psc, tbl[i].arr,
           tbl[i].cnt, tbl[i].irq, $sformatf("vec%0d", i));

    // Periodic psc=3 arr=4: count advances every 4 cycles, pulse every 20.
    step(1,0,1,1, 8'd3,8'd4, 8'd0,1'b0, "p34_rst");
    step(0,0,1,1, 8'd3,8'd4, 8'd0,1'b0, "p34_start");
    n_pulse = 0;
    for (int k = 1; k <= 100; k++)
      step(0,0,1,1, 8'd3,8'd4, W'((k / 4) % 5), 1'(k % 20 == 0), $sformatf("p34_k%0d", k));
    n_vec++;
    if (n_pulse != 5) begin
      n_bad++;
      $display("FAIL p34_pulses: got %0d pulses, required 5", n_pulse);
    end

    // One-shot psc=0 arr=9: single pulse, count parks at 9.
    step(1,0,0,0, 8'd0,8'd9, 8'd0,1'b0, "os_rst");
    step(0,0,1,0, 8'd0,8'd9, 8'd0,1'b0, "os_start");
    for (int k = 1; k <= 60; k++)
      step(0,0,1,0, 8'd0,8'd9, W'(k < 9 ? k : 9), 1'(k == 10), $sformatf("os_k%0d", k));
    step(0,0,0,0, 8'd0,8'd9, 8'd9,1'b0, "os_idle");
    step(0,0,0,0, 8'd0,8'd9, 8'd9,1'b0, "os_idle2");
    step(0,0,1,0, 8'd0,8'd9, 8'd0,1'b0, "os_restart");
    step(0,0,1,0, 8'd0,8'd9, 8'd1,1'b0, "os_restart_tick");

    // Periodic psc=1 arr=5 with a 10-cycle pause at count 2.
    step(1,0,0,1, 8'd1,8'd5, 8'd0,1'b0, "pz_rst");
    step(0,0,1,1, 8'd1,8'd5, 8'd0,1'b0, "pz_start");
    for (int k = 1; k <= 26; k++) begin
      step(0,0,1,1, 8'd1,8'd5, W'((k / 2) % 6), 1'(k % 12 == 0), $sformatf("pz_k%0d", k));
      if (k == 4)
        for (int j = 0; j < 10; j++)
          step(0,0,0,1, 8'd1,8'd5, 8'd2,1'b0, $sformatf("pz_hold%0d", j));
    end

    // Autoreload 4 -> 7 mid-period: one 5-tick period, then 8-tick periods.
    step(1,0,0,1, 8'd0,8'd4, 8'd0,1'b0, "ar_rst");
    step(0,0,1,1, 8'd0,8'd4, 8'd0,1'b0, "ar_start");
    for (int k = 1; k <= 25; k++) begin
      if (k <= 5)
        step(0,0,1,1, 8'd0, (k <= 2) ? 8'd4 : 8'd7, W'(k % 5), 1'(k == 5), $sformatf("ar_k%0d", k));
      else
        step(0,0,1,1, 8'd0,8'd7, W'((k - 5) % 8), 1'((k - 5) % 8 == 0), $sformatf("ar_k%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
